// File: rtl/kf8237_transfer_sequencer_pkg.sv
// Shared definitions for the KF8237 transfer sequencer: bus-cycle state
// encoding, transfer mode codes and channel one-hot/index helpers.
package kf8237_transfer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_SI = 3'd0,   // idle, bus owned by CPU
        ST_S0 = 3'd1,   // HRQ raised, waiting for HLDA
        ST_S1 = 3'd2,   // upper address strobe cycle
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_S4 = 3'd5,   // word completes, current registers advance
        ST_SC = 3'd6    // cascade: bus handed to a slave controller
    } state_e;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    // Channel number of a one-hot select; a malformed vector maps to ch0.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // One-hot select for a channel number.
    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/kf8237_priority_arbiter.sv
// Four-channel DREQ resolver. Fixed mode always starts the search at ch0;
// rotating mode starts at the channel after the one most recently serviced.
module kf8237_priority_arbiter
    import kf8237_transfer_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] request,
    input  logic       rotating_priority,
    input  logic       rotate_strobe,
    input  logic [3:0] serviced,
    output logic [3:0] grant
);

    logic [1:0] pointer_q;
    logic [1:0] pointer_d;
    logic [1:0] base_s;
    logic [1:0] idx_s;

    // Scan from lowest to highest priority so the highest active request wins
    always_comb begin
        grant  = 4'b0000;
        idx_s  = 2'd0;
        if (rotating_priority) begin
            base_s = pointer_q;
        end else begin
            base_s = 2'd0;
        end
        for (int i = 3; i >= 0; i--) begin
            idx_s = base_s + i[1:0];
            grant = request[idx_s] ? idx_to_onehot(idx_s) : grant;
        end
    end

    // The serviced channel becomes lowest, so the next one up becomes highest
    always_comb begin
        if (rotate_strobe && rotating_priority) begin
            pointer_d = onehot_to_idx(serviced) + 2'd1;
        end else begin
            pointer_d = pointer_q;
        end
    end

    // Rotation pointer register, ch0 highest out of reset
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pointer_q <= 2'd0;
        end else begin
            pointer_q <= pointer_d;
        end
    end

endmodule

// File: rtl/kf8237_transfer_sequencer.sv
// KF8237 timing-and-control sequencer: arbitrates DREQ, runs the HRQ/HLDA
// handshake, steps SI/S0/S1-S4/SC and drives the per-word strobes into the
// address/count register file. State advances on the falling clock edge so
// the register file samples the decoded strobes on that same edge.
module kf8237_transfer_sequencer
    import kf8237_transfer_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] dma_request,
    input  logic       hold_acknowledge,
    input  logic       end_of_process_in,
    input  logic [7:0] transfer_mode,
    input  logic [3:0] autoinitialize,
    input  logic       disable_controller,
    input  logic       rotating_priority,
    input  logic       underflow,
    input  logic       update_high_address,
    output logic       hold_request,
    output logic [3:0] dma_acknowledge,
    output logic [3:0] transfer_register_select,
    output logic       next_word,
    output logic       initialize_current_register,
    output logic       address_strobe,
    output logic       address_enable,
    output logic       end_of_process_out,
    output logic [3:0] terminal_count
);

    state_e     state_q;
    state_e     state_d;
    state_e     continue_s;
    logic [3:0] winner_q;
    logic [3:0] winner_d;
    logic       init_pending_q;
    logic       init_pending_d;
    logic [3:0] arb_request_s;
    logic [3:0] grant_s;
    logic [1:0] winner_mode_s;
    logic       winner_request_s;
    logic       word_done_s;
    logic       terminal_s;
    logic       rotate_s;

    // A disabled controller sees no requests at all
    assign arb_request_s    = disable_controller ? 4'b0000 : dma_request;
    assign winner_request_s = |(dma_request & winner_q);
    // A word only completes if the bus is still granted in S4
    assign word_done_s      = (state_q == ST_S4) && hold_acknowledge;
    // underflow and EOP together still make a single terminal event
    assign terminal_s       = word_done_s && (underflow || end_of_process_in);
    assign rotate_s         = (state_q != ST_SI) && (state_d == ST_SI);
    // Next word needs a fresh upper-address strobe when bit 8 carried
    assign continue_s       = update_high_address ? ST_S1 : ST_S2;

    kf8237_priority_arbiter u_arbiter (
        .clock             (clock),
        .reset_n           (reset_n),
        .request           (arb_request_s),
        .rotating_priority (rotating_priority),
        .rotate_strobe     (rotate_s),
        .serviced          (winner_q),
        .grant             (grant_s)
    );

    // Transfer mode of the latched channel
    always_comb begin
        case (onehot_to_idx(winner_q))
            2'd0:    winner_mode_s = transfer_mode[1:0];
            2'd1:    winner_mode_s = transfer_mode[3:2];
            2'd2:    winner_mode_s = transfer_mode[5:4];
            2'd3:    winner_mode_s = transfer_mode[7:6];
            default: winner_mode_s = MODE_DEMAND;
        endcase
    end

    // Next state, channel latch and autoinit request
    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        init_pending_d = 1'b0;
        case (state_q)
            ST_SI: begin
                // Selection is only re-evaluated here and frozen otherwise
                winner_d = grant_s;
                if (grant_s != 4'b0000) begin
                    state_d = ST_S0;
                end else begin
                    state_d = ST_SI;
                end
            end
            ST_S0: begin
                if (hold_acknowledge) begin
                    state_d = (winner_mode_s == MODE_CASCADE) ? ST_SC : ST_S1;
                end else begin
                    state_d = ST_S0;
                end
            end
            ST_S1: state_d = hold_acknowledge ? ST_S2 : ST_SI;
            ST_S2: state_d = hold_acknowledge ? ST_S3 : ST_SI;
            ST_S3: state_d = hold_acknowledge ? ST_S4 : ST_SI;
            ST_S4: begin
                if (!hold_acknowledge) begin
                    state_d = ST_SI;
                end else if (terminal_s) begin
                    state_d        = ST_SI;
                    init_pending_d = |(autoinitialize & winner_q);
                end else begin
                    case (winner_mode_s)
                        MODE_SINGLE: state_d = ST_SI;
                        MODE_BLOCK:  state_d = continue_s;
                        MODE_DEMAND: state_d = winner_request_s ? continue_s : ST_SI;
                        default:     state_d = ST_SI;
                    endcase
                end
            end
            ST_SC: state_d = winner_request_s ? ST_SC : ST_SI;
            default: state_d = ST_SI;
        endcase
    end

    // Bus-cycle decodes of the registered state
    always_comb begin
        hold_request    = 1'b0;
        address_enable  = 1'b0;
        address_strobe  = 1'b0;
        dma_acknowledge = 4'b0000;
        case (state_q)
            ST_SI: hold_request = 1'b0;
            ST_S0: hold_request = 1'b1;
            ST_S1: begin
                hold_request   = 1'b1;
                address_enable = 1'b1;
                address_strobe = 1'b1;
            end
            ST_S2, ST_S3, ST_S4: begin
                hold_request    = 1'b1;
                address_enable  = 1'b1;
                dma_acknowledge = winner_q;
            end
            ST_SC: begin
                hold_request    = 1'b1;
                dma_acknowledge = winner_q;
            end
            default: hold_request = 1'b0;
        endcase
    end

    assign transfer_register_select    = winner_q;
    assign next_word                   = word_done_s;
    assign end_of_process_out          = terminal_s;
    assign terminal_count              = terminal_s ? winner_q : 4'b0000;
    assign initialize_current_register = init_pending_q;

    // Sequencer state registers
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_SI;
            winner_q       <= 4'b0000;
            init_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            init_pending_q <= init_pending_d;
        end
    end

endmodule

// File: tb/tb_kf8237_transfer_sequencer.sv
// Directed bench for kf8237_transfer_sequencer: per-cycle vector tables for
// the single/block/demand/cascade flows plus hand sequences for priority
// rotation and mid-transfer reset. Inputs change just after the falling
// (active) edge; outputs are sampled on the rising edge.
module tb_kf8237_transfer_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] dma_request;
    logic       hold_acknowledge;
    logic       end_of_process_in;
    logic [7:0] transfer_mode;
    logic [3:0] autoinitialize;
    logic       disable_controller;
    logic       rotating_priority;
    logic       underflow;
    logic       update_high_address;
    logic       hold_request;
    logic [3:0] dma_acknowledge;
    logic [3:0] transfer_register_select;
    logic       next_word;
    logic       initialize_current_register;
    logic       address_strobe;
    logic       address_enable;
    logic       end_of_process_out;
    logic [3:0] terminal_count;

    int checks   = 0;
    int failures = 0;

    kf8237_transfer_sequencer dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .dma_request                 (dma_request),
        .hold_acknowledge            (hold_acknowledge),
        .end_of_process_in           (end_of_process_in),
        .transfer_mode               (transfer_mode),
        .autoinitialize              (autoinitialize),
        .disable_controller          (disable_controller),
        .rotating_priority           (rotating_priority),
        .underflow                   (underflow),
        .update_high_address         (update_high_address),
        .hold_request                (hold_request),
        .dma_acknowledge             (dma_acknowledge),
        .transfer_register_select    (transfer_register_select),
        .next_word                   (next_word),
        .initialize_current_register (initialize_current_register),
        .address_strobe              (address_strobe),
        .address_enable              (address_enable),
        .end_of_process_out          (end_of_process_out),
        .terminal_count              (terminal_count)
    );

    always #5 clock = ~clock;

    // {hrq, dack[3:0], trs[3:0], nw, icr, adstb, aen, eop, tc[3:0]}
    logic [17:0] obs_s;
    assign obs_s = {hold_request, dma_acknowledge, transfer_register_select, next_word,
                    initialize_current_register, address_strobe, address_enable,
                    end_of_process_out, terminal_count};

    typedef struct {
        logic [3:0]  dreq;
        logic        hlda;
        logic        uf;
        logic        eop;
        logic        uha;
        logic        dis;
        logic [17:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [17:0] ex(input logic hrq, input logic [3:0] dack, input logic [3:0] trs,
                                       input logic nw, input logic icr, input logic adstb,
                                       input logic aen, input logic eop, input logic [3:0] tc);
        return {hrq, dack, trs, nw, icr, adstb, aen, eop, tc};
    endfunction

    // Hand-written output templates for each bus state
    function automatic logic [17:0] e_si(input logic [3:0] c, input logic icr);
        return ex(1'b0, 4'b0000, c, 1'b0, icr, 1'b0, 1'b0, 1'b0, 4'b0000);
    endfunction
    function automatic logic [17:0] e_s0(input logic [3:0] c);
        return ex(1'b1, 4'b0000, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endfunction
    function automatic logic [17:0] e_s1(input logic [3:0] c);
        return ex(1'b1, 4'b0000, c, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    endfunction
    function automatic logic [17:0] e_s23(input logic [3:0] c);
        return ex(1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    endfunction
    function automatic logic [17:0] e_s4(input logic [3:0] c, input logic t);
        return ex(1'b1, c, c, 1'b1, 1'b0, 1'b0, 1'b1, t, t ? c : 4'b0000);
    endfunction
    function automatic logic [17:0] e_sc(input logic [3:0] c);
        return ex(1'b1, c, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endfunction

    function automatic void add(input logic [3:0] dreq, input logic hlda, input logic uf,
                                input logic eop, input logic uha, input logic dis,
                                input logic [17:0] exp);
        vec_t v;
        v.dreq = dreq; v.hlda = hlda; v.uf = uf; v.eop = eop; v.uha = uha; v.dis = dis;
        v.exp  = exp;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%05h required=%05h", name, act, exp);
        end
    endtask

    // One vector per clock cycle: drive after the falling edge, check on the rising edge
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            dma_request         = vq[i].dreq;
            hold_acknowledge    = vq[i].hlda;
            underflow           = vq[i].uf;
            end_of_process_in   = vq[i].eop;
            update_high_address = vq[i].uha;
            disable_controller  = vq[i].dis;
            @(posedge clock);
            chk($sformatf("%s[%0d]", tag, i), obs_s, vq[i].exp);
            @(negedge clock);
            #1;
        end
        vq.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        @(negedge clock);
        #1;
    endtask

    // Wait for the next DACK, check which channel got it, then wait for HRQ to drop
    task automatic serve_expect(input logic [3:0] exp_ch, input string tag);
        int n;
        n = 0;
        @(posedge clock);
        while ((dma_acknowledge == 4'b0000) && (n < 40)) begin
            @(posedge clock);
            n++;
        end
        chk(tag, {14'd0, dma_acknowledge}, {14'd0, exp_ch});
        n = 0;
        while ((hold_request == 1'b1) && (n < 40)) begin
            @(posedge clock);
            n++;
        end
        chk({tag, "_hrq_drop"}, {17'd0, hold_request}, 18'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        dma_request = 4'b0000; hold_acknowledge = 1'b0; end_of_process_in = 1'b0;
        transfer_mode = 8'h00; autoinitialize = 4'b0000; disable_controller = 1'b0;
        rotating_priority = 1'b0; underflow = 1'b0; update_high_address = 1'b0;
        #3;
        chk("reset_outputs", obs_s, 18'd0);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        #1;

        // ch2 single, HLDA after two S0 cycles
        transfer_mode = 8'h10;
        add(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        add(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_s0(4'b0100));
        add(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s0(4'b0100));
        add(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s1(4'b0100));
        add(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0100));
        add(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0100));
        add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s4(4'b0100, 1'b0));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0100, 1'b0));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        // controller disabled: requests ignored
        add(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e_si(4'b0000, 1'b0));
        add(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e_si(4'b0000, 1'b0));
        run_vecs("single_ch2");

        // ch0 block with autoinit; terminal on 3rd S4 (underflow and EOP together)
        transfer_mode = 8'h02; autoinitialize = 4'b0001;
        add(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        add(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e_s0(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s1(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s4(4'b0001, 1'b0));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s4(4'b0001, 1'b0));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e_s4(4'b0001, 1'b1));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0001, 1'b1));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        run_vecs("block_tc");

        // ch0 block: address-bit-8 carry on word 1 forces S1 before word 2 only
        autoinitialize = 4'b0000;
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s0(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s1(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, e_s4(4'b0001, 1'b0));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s1(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s4(4'b0001, 1'b0));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e_s4(4'b0001, 1'b1));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0001, 1'b0));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        run_vecs("block_uha");

        // ch1 demand, request withdrawn in S3
        transfer_mode = 8'h00;
        add(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        add(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s0(4'b0010));
        add(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s1(4'b0010));
        add(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0010));
        add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s23(4'b0010));
        add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s4(4'b0010, 1'b0));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0010, 1'b0));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        run_vecs("demand_ch1");

        // ch3 cascade: DACK while request high, no strobes
        transfer_mode = 8'hC0;
        add(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        add(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s0(4'b1000));
        add(4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e_sc(4'b1000));
        add(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_sc(4'b1000));
        add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_sc(4'b1000));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b1000, 1'b0));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        run_vecs("cascade_ch3");

        // HLDA lost in S2: abandon without next_word
        transfer_mode = 8'h02;
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s0(4'b0001));
        add(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_s1(4'b0001));
        add(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_s23(4'b0001));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0001, 1'b0));
        add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_si(4'b0000, 1'b0));
        run_vecs("hlda_drop");

        // Rotating priority, all requests held, single mode
        do_reset();
        transfer_mode = 8'h55; rotating_priority = 1'b1;
        dma_request = 4'b1111; hold_acknowledge = 1'b1;
        serve_expect(4'b0001, "rot_0");
        serve_expect(4'b0010, "rot_1");
        serve_expect(4'b0100, "rot_2");
        serve_expect(4'b1000, "rot_3");
        serve_expect(4'b0001, "rot_4");
        #1;
        dma_request = 4'b0000; hold_acknowledge = 1'b0;
        @(negedge clock);
        #1;

        // Fixed priority: ch0 every time
        do_reset();
        rotating_priority = 1'b0;
        dma_request = 4'b1111; hold_acknowledge = 1'b1;
        serve_expect(4'b0001, "fix_0");
        serve_expect(4'b0001, "fix_1");
        serve_expect(4'b0001, "fix_2");
        #1;
        dma_request = 4'b0000; hold_acknowledge = 1'b0;
        @(negedge clock);
        #1;

        // Asynchronous reset while in S2
        do_reset();
        transfer_mode = 8'h02;
        dma_request = 4'b0001; hold_acknowledge = 1'b1;
        repeat (3) begin
            @(negedge clock);
            #1;
        end
        @(posedge clock);
        chk("rst_pre_s2", obs_s, e_s23(4'b0001));
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid", obs_s, 18'd0);
        dma_request = 4'b0000; hold_acknowledge = 1'b0;
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        @(posedge clock);
        chk("rst_after", obs_s, 18'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
